// File: rtl/processor_system_st_ram_pkg.sv
// Shared constants for the stream-to-RAM writer.
// CSR map, CTRL/STATUS bit positions and FSM states.
package processor_system_st_ram_pkg;

    localparam int LEN_W = 11;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_BASE   = 2'd1;
    localparam logic [1:0] CSR_LIMIT  = 2'd2;
    localparam logic [1:0] CSR_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_WRAP   = 2;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_ABORT   = 3;
    localparam int ST_LEN_LSB = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/processor_system_st_ram_csr.sv
// CSR slave: CTRL/BASE/LIMIT registers, sticky W1C status flags,
// registered level irq and latency-1 read data.
module processor_system_st_ram_csr #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq,
    input  logic              i_busy,
    input  logic              i_done,
    input  logic              i_ovf,
    input  logic              i_abort,
    input  logic [LEN_W-1:0]  i_last_len,
    output logic              o_en,
    output logic              o_wrap,
    output logic [ADDR_W-1:0] o_base,
    output logic [ADDR_W-1:0] o_limit
);
    import processor_system_st_ram_pkg::*;

    logic [2:0]        r_ctrl;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_limit;
    logic              r_done;
    logic              r_ovf;
    logic              r_abort;
    logic [LEN_W-1:0]  r_len;
    logic              r_irq;
    logic [31:0]       r_rdata;
    logic [31:0]       w_rd;
    logic              w_wr_st;
    logic              w_unused;

    assign w_wr_st  = csr_write & (csr_address == CSR_STATUS);
    assign w_unused = ^csr_writedata[31:ADDR_W];

    always_comb begin
        w_rd = '0;
        unique case (csr_address)
            CSR_CTRL:  w_rd[2:0] = r_ctrl;
            CSR_BASE:  w_rd[ADDR_W-1:0] = r_base;
            CSR_LIMIT: w_rd[ADDR_W-1:0] = r_limit;
            CSR_STATUS: begin
                w_rd[ST_BUSY]  = i_busy;
                w_rd[ST_DONE]  = r_done;
                w_rd[ST_OVF]   = r_ovf;
                w_rd[ST_ABORT] = r_abort;
                w_rd[ST_LEN_LSB +: LEN_W] = r_len;
            end
        endcase
    end

    // Event inputs are OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl  <= '0;
            r_base  <= '0;
            r_limit <= '1;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_abort <= 1'b0;
            r_len   <= '0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (csr_write && csr_address == CSR_CTRL)
                r_ctrl <= csr_writedata[2:0];
            if (csr_write && csr_address == CSR_BASE)
                r_base <= csr_writedata[ADDR_W-1:0];
            if (csr_write && csr_address == CSR_LIMIT)
                r_limit <= csr_writedata[ADDR_W-1:0];
            r_done  <= i_done  | (r_done  & ~(w_wr_st & csr_writedata[ST_DONE]));
            r_ovf   <= i_ovf   | (r_ovf   & ~(w_wr_st & csr_writedata[ST_OVF]));
            r_abort <= i_abort | (r_abort & ~(w_wr_st & csr_writedata[ST_ABORT]));
            if (i_done)
                r_len <= i_last_len;
            r_irq <= r_ctrl[CTRL_IRQ_EN] & (r_done | r_ovf | r_abort);
            if (csr_read)
                r_rdata <= w_rd;
        end
    end

    assign csr_readdata = r_rdata;
    assign irq          = r_irq;
    assign o_en         = r_ctrl[CTRL_EN];
    assign o_wrap       = r_ctrl[CTRL_WRAP];
    assign o_base       = r_base;
    assign o_limit      = r_limit;

endmodule

// File: rtl/processor_system_st_to_ram_writer.sv
// Avalon-ST sink that writes packets into a RAM window [BASE..LIMIT],
// with wrap or overflow-drain at the window end.
module processor_system_st_to_ram_writer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic              snk_sop,
    input  logic              snk_eop,
    input  logic [1:0]        snk_empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic [3:0]        ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [1:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              irq
);
    import processor_system_st_ram_pkg::*;

    state_t            r_state, w_state_n;
    logic [ADDR_W-1:0] r_ptr, w_ptr_n;
    logic [ADDR_W-1:0] r_base, r_limit;
    logic              r_wrap;
    logic [LEN_W-1:0]  r_len, w_len_n;
    logic [ADDR_W-1:0] w_csr_base, w_csr_limit;
    logic              w_csr_wrap, w_en;
    logic [ADDR_W-1:0] w_base, w_limit, w_waddr;
    logic              w_wrap;
    logic [LEN_W-1:0]  w_wlen, w_last_len;
    logic              w_acc, w_restart, w_wr;
    logic              w_done, w_ovf, w_abort;
    logic [3:0]        w_be;
    logic              r_ram_write;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic [3:0]        r_ram_be;

    assign snk_ready = w_en & reset_n;
    assign w_acc     = snk_valid & snk_ready;

    // A sop outside DRAIN (re)starts a packet with freshly sampled window regs.
    assign w_restart = w_acc & snk_sop & (r_state != DRAIN);
    assign w_base    = w_restart ? w_csr_base  : r_base;
    assign w_limit   = w_restart ? w_csr_limit : r_limit;
    assign w_wrap    = w_restart ? w_csr_wrap  : r_wrap;
    assign w_waddr   = w_restart ? w_csr_base  : r_ptr;
    assign w_wlen    = w_restart ? LEN_W'(1) :
                       ((&r_len) ? r_len : r_len + 1'b1);
    assign w_wr      = w_acc & (w_restart | (r_state == PKT));
    assign w_abort   = w_restart & (r_state == PKT);
    assign w_be      = snk_eop ? (4'hF >> snk_empty) : 4'hF;

    always_comb begin
        w_state_n  = r_state;
        w_ptr_n    = r_ptr;
        w_len_n    = r_len;
        w_done     = 1'b0;
        w_ovf      = 1'b0;
        w_last_len = r_len;
        if (w_wr) begin
            w_len_n = w_wlen;
            if (snk_eop) begin
                w_state_n  = IDLE;
                w_done     = 1'b1;
                w_last_len = w_wlen;
            end else if (w_waddr == w_limit && w_wrap) begin
                w_state_n = PKT;
                w_ptr_n   = w_base;
            end else if (w_waddr == w_limit) begin
                w_state_n = DRAIN;
                w_ovf     = 1'b1;
            end else begin
                w_state_n = PKT;
                w_ptr_n   = w_waddr + 1'b1;
            end
        end else if (w_acc && snk_eop && r_state == DRAIN) begin
            w_state_n = IDLE;
            w_done    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_len       <= '0;
            r_base      <= '0;
            r_limit     <= '1;
            r_wrap      <= 1'b0;
            r_ram_write <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_ram_be    <= '0;
        end else begin
            r_state     <= w_state_n;
            r_ptr       <= w_ptr_n;
            r_len       <= w_len_n;
            r_ram_write <= w_wr;
            if (w_restart) begin
                r_base  <= w_csr_base;
                r_limit <= w_csr_limit;
                r_wrap  <= w_csr_wrap;
            end
            if (w_wr) begin
                r_ram_addr <= w_waddr;
                r_ram_data <= snk_data;
                r_ram_be   <= w_be;
            end
        end
    end

    assign ram_address    = r_ram_addr;
    assign ram_writedata  = r_ram_data;
    assign ram_byteenable = r_ram_be;
    assign ram_write      = r_ram_write;
    assign ram_chipselect = r_ram_write;
    assign ram_clken      = 1'b1;

    processor_system_st_ram_csr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_csr (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .irq           (irq),
        .i_busy        (r_state != IDLE),
        .i_done        (w_done),
        .i_ovf         (w_ovf),
        .i_abort       (w_abort),
        .i_last_len    (w_last_len),
        .o_en          (w_en),
        .o_wrap        (w_csr_wrap),
        .o_base        (w_csr_base),
        .o_limit       (w_csr_limit)
    );

endmodule

// File: tb/tb_processor_system_st_to_ram_writer.sv
// Directed bench for the stream-to-RAM writer: table of packet
// scenarios plus irq, abort/backpressure and async-reset sequences.
module tb_processor_system_st_to_ram_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic        snk_sop = 1'b0;
    logic        snk_eop = 1'b0;
    logic [1:0]  snk_empty = '0;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [1:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    processor_system_st_to_ram_writer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .snk_sop        (snk_sop),
        .snk_eop        (snk_eop),
        .snk_empty      (snk_empty),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .csr_address    (csr_address),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]       base;
        logic [9:0]       limit;
        logic [2:0]       ctrl;
        int               n;
        logic [1:0]       emp;
        logic [31:0]      d0;
        int               nwr;
        logic [4:0][9:0]  a;
        logic [31:0]      st;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    vec_t vt[5];
    wr_t  wq[$];

    always @(negedge clk)
        if (ram_write === 1'b1)
            wq.push_back('{ram_address, ram_writedata, ram_byteenable});

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        csr_address = a;
        csr_writedata = d;
        csr_write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        csr_address = a;
        csr_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask

    task automatic beat(input logic s, input logic e,
                        input logic [1:0] em, input logic [31:0] d);
        int t;
        t = 0;
        snk_valid = 1'b1;
        snk_sop = s;
        snk_eop = e;
        snk_empty = em;
        snk_data = d;
        while (!snk_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!snk_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_accept: snk_ready got 0 want 1");
        end
        @(posedge clk);
        @(negedge clk);
        snk_valid = 1'b0;
        snk_sop = 1'b0;
        snk_eop = 1'b0;
        snk_empty = '0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  ebe;
        int          sz;

        vt[0] = '{base:10'd16, limit:10'd31, ctrl:3'd1, n:4, emp:2'd0,
                  d0:32'hA0, nwr:4,
                  a:{10'd0, 10'd19, 10'd18, 10'd17, 10'd16},
                  st:32'h0004_0002};
        vt[1] = '{base:10'd8, limit:10'd9, ctrl:3'd5, n:5, emp:2'd0,
                  d0:32'hB0, nwr:5,
                  a:{10'd8, 10'd9, 10'd8, 10'd9, 10'd8},
                  st:32'h0005_0002};
        vt[2] = '{base:10'd8, limit:10'd9, ctrl:3'd1, n:5, emp:2'd0,
                  d0:32'hC0, nwr:2,
                  a:{10'd0, 10'd0, 10'd0, 10'd9, 10'd8},
                  st:32'h0002_0006};
        vt[3] = '{base:10'd1022, limit:10'd1, ctrl:3'd1, n:4, emp:2'd2,
                  d0:32'hD0, nwr:4,
                  a:{10'd0, 10'd1, 10'd0, 10'd1023, 10'd1022},
                  st:32'h0004_0002};
        vt[4] = '{base:10'd5, limit:10'd5, ctrl:3'd1, n:3, emp:2'd0,
                  d0:32'hE0, nwr:1,
                  a:{10'd0, 10'd0, 10'd0, 10'd0, 10'd5},
                  st:32'h0001_0006};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(snk_ready), 32'd0);
        chk("rst_write", 32'(ram_write), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_clken", 32'(ram_clken), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        csr_rd(2'd0, rd); chk("rst_ctrl", rd, 32'd0);
        csr_rd(2'd1, rd); chk("rst_base", rd, 32'd0);
        csr_rd(2'd2, rd); chk("rst_limit", rd, 32'd1023);
        csr_rd(2'd3, rd); chk("rst_status", rd, 32'd0);

        // table-driven packets
        for (int i = 0; i < 5; i++) begin
            csr_wr(2'd0, 32'd0);
            csr_wr(2'd3, 32'hE);
            csr_wr(2'd1, 32'(vt[i].base));
            csr_wr(2'd2, 32'(vt[i].limit));
            csr_wr(2'd0, 32'(vt[i].ctrl));
            wq.delete();
            for (int j = 0; j < vt[i].n; j++)
                beat(j == 0, j == vt[i].n - 1,
                     (j == vt[i].n - 1) ? vt[i].emp : 2'd0,
                     vt[i].d0 + 32'(j));
            repeat (2) @(negedge clk);
            chk($sformatf("c%0d_nwr", i), 32'(wq.size()), 32'(vt[i].nwr));
            for (int k = 0; k < vt[i].nwr && k < wq.size(); k++) begin
                ebe = (k == vt[i].n - 1) ? (4'hF >> vt[i].emp) : 4'hF;
                chk($sformatf("c%0d_addr%0d", i, k),
                    32'(wq[k].addr), 32'(vt[i].a[k]));
                chk($sformatf("c%0d_data%0d", i, k),
                    wq[k].data, vt[i].d0 + 32'(k));
                chk($sformatf("c%0d_be%0d", i, k), 32'(wq[k].be), 32'(ebe));
            end
            csr_rd(2'd3, rd);
            chk($sformatf("c%0d_status", i), rd, vt[i].st);
            chk($sformatf("c%0d_irq", i), 32'(irq), 32'd0);
        end

        // partial last word and irq timing
        csr_wr(2'd0, 32'd0);
        csr_wr(2'd3, 32'hE);
        csr_wr(2'd1, 32'd16);
        csr_wr(2'd2, 32'd31);
        csr_wr(2'd0, 32'd3);
        wq.delete();
        beat(1'b1, 1'b0, 2'd0, 32'h1111_00B0);
        beat(1'b0, 1'b0, 2'd0, 32'h1111_00B1);
        beat(1'b0, 1'b1, 2'd1, 32'h1111_00B2);
        chk("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), 32'd1);
        chk("part_nwr", 32'(wq.size()), 32'd3);
        if (wq.size() == 3) begin
            chk("part_addr", 32'(wq[2].addr), 32'd18);
            chk("part_be", 32'(wq[2].be), 32'h7);
        end
        csr_wr(2'd3, 32'h2);
        chk("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        chk("irq_clear", 32'(irq), 32'd0);
        csr_rd(2'd3, rd);
        chk("part_status", rd, 32'h0003_0000);

        // abort and enable backpressure
        csr_wr(2'd0, 32'd1);
        csr_wr(2'd3, 32'hE);
        wq.delete();
        beat(1'b1, 1'b0, 2'd0, 32'hC0);
        beat(1'b0, 1'b0, 2'd0, 32'hC1);
        beat(1'b1, 1'b0, 2'd0, 32'hC2);
        csr_wr(2'd0, 32'd0);
        sz = wq.size();
        chk("bp_ready", 32'(snk_ready), 32'd0);
        csr_rd(2'd3, rd);
        chk("bp_status", rd, 32'h0003_0009);
        snk_valid = 1'b1;
        snk_data = 32'hC9;
        repeat (3) @(negedge clk);
        chk("bp_nowrite", 32'(wq.size()), 32'(sz));
        snk_valid = 1'b0;
        csr_wr(2'd0, 32'd1);
        beat(1'b0, 1'b0, 2'd0, 32'hC3);
        beat(1'b0, 1'b1, 2'd0, 32'hC4);
        repeat (2) @(negedge clk);
        chk("ab_nwr", 32'(wq.size()), 32'd5);
        if (wq.size() == 5) begin
            chk("ab_restart", 32'(wq[2].addr), 32'd16);
            chk("ab_resume", 32'(wq[3].addr), 32'd17);
            chk("ab_last", 32'(wq[4].addr), 32'd18);
            chk("ab_data", wq[4].data, 32'hC4);
        end
        csr_rd(2'd3, rd);
        chk("ab_status", rd, 32'h0003_000A);

        // async reset mid-packet
        beat(1'b1, 1'b0, 2'd0, 32'h55);
        chk("ar_write_pre", 32'(ram_write), 32'd1);
        chk("ar_addr_pre", 32'(ram_address), 32'd16);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_ready", 32'(snk_ready), 32'd0);
        chk("ar_write", 32'(ram_write), 32'd0);
        chk("ar_cs", 32'(ram_chipselect), 32'd0);
        chk("ar_addr", 32'(ram_address), 32'd0);
        chk("ar_data", ram_writedata, 32'd0);
        chk("ar_be", 32'(ram_byteenable), 32'd0);
        chk("ar_rdata", csr_readdata, 32'd0);
        chk("ar_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        csr_rd(2'd0, rd); chk("ar_ctrl", rd, 32'd0);
        chk("ar_ready_post", 32'(snk_ready), 32'd0);
        csr_rd(2'd3, rd); chk("ar_status", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
